dcache_bus_bridge: RTL and testbench

- Memory-side responder for the core's data port (`Mem_Dcache*` / `EXMem_Rs2Data` in, `Dcache_DataRd` out).
- Converts each single-cycle core load/store into a valid/ready transaction on an external word-wide bus.
- Holds the pipeline through `Dcache_StallReq` until the access completes.
- Formats load data (byte/half/word, sign/zero extension) and generates write strobes.

---
 rtl/dcache_bus_bridge.sv | 179 +++++++++++++++++
 tb/tb_dcache_bus_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_bus_bridge.sv
// Data-port bridge: turns single-cycle core loads/stores into valid/ready bus
// transactions, stalls the pipeline until completion and formats load data.
//   state | meaning
//   IDLE  | waiting for an aligned access from the Mem stage
//   REQ   | Bus_ReqValid held with stable fields until Bus_ReqReady
//   RESP  | waiting for Bus_RspValid, bounded by the timeout counter
//   DONE  | one-cycle completion: load data / bus error visible
module dcache_bus_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Mem_DcacheEN,
  input  logic                  Mem_DcacheRd,
  input  logic [1:0]            Mem_DcacheWidth,
  input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
  input  logic                  Mem_DcacheSign,
  input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
  output logic [DATA_WIDTH-1:0] Dcache_DataRd,
  output logic                  Dcache_StallReq,
  output logic                  Dcache_Misalign,
  output logic                  Dcache_BusErr,
  output logic                  Bus_ReqValid,
  input  logic                  Bus_ReqReady,
  output logic                  Bus_ReqWe,
  output logic [ADDR_WIDTH-1:0] Bus_ReqAddr,
  output logic [DATA_WIDTH-1:0] Bus_ReqWdata,
  output logic [3:0]            Bus_ReqStrb,
  input  logic                  Bus_RspValid,
  input  logic [DATA_WIDTH-1:0] Bus_RspData,
  input  logic                  Bus_RspErr
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_strb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_width;
  logic                  r_sign;
  logic [1:0]            r_lane;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_bad;
  logic                  w_accept;
  logic                  w_timeout;
  logic [3:0]            w_strb;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_fmt;

  always_comb begin
    w_bad = 1'b0;
    case (Mem_DcacheWidth)
      2'b01:   w_bad = Mem_DcacheAddr[0];
      2'b10:   w_bad = |Mem_DcacheAddr[1:0];
      2'b11:   w_bad = 1'b1;
      default: w_bad = 1'b0;
    endcase
  end

  assign w_accept  = Mem_DcacheEN & ~w_bad;
  assign w_timeout = (r_cnt == CNT_LAST);

  // Loads carry no strobes; stores replicate data onto every lane.
  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = EXMem_Rs2Data;
    case (Mem_DcacheWidth)
      2'b00: begin
        w_strb  = 4'b0001 << Mem_DcacheAddr[1:0];
        w_wdata = {4{EXMem_Rs2Data[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << Mem_DcacheAddr[1:0];
        w_wdata = {2{EXMem_Rs2Data[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = EXMem_Rs2Data;
      end
    endcase
    if (Mem_DcacheRd) w_strb = 4'b0000;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = REQ;
      REQ:  if (Bus_ReqReady) w_next = RESP;
      RESP: if (Bus_RspValid || w_timeout) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_strb  <= 4'b0000;
      r_wdata <= '0;
      r_width <= 2'b00;
      r_sign  <= 1'b0;
      r_lane  <= 2'b00;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= ~Mem_DcacheRd;
            r_addr  <= {Mem_DcacheAddr[ADDR_WIDTH-1:2], 2'b00};
            r_strb  <= w_strb;
            r_wdata <= w_wdata;
            r_width <= Mem_DcacheWidth;
            r_sign  <= Mem_DcacheSign;
            r_lane  <= Mem_DcacheAddr[1:0];
            r_err   <= 1'b0;
          end
        end
        REQ: if (Bus_ReqReady) r_cnt <= '0;
        RESP: begin
          // A response in the timeout cycle takes priority over the error.
          if (Bus_RspValid) begin
            r_rdata <= Bus_RspData;
            r_err   <= Bus_RspErr;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      2'd3:    w_byte = r_rdata[31:24];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_lane[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_width)
      2'b00:   w_fmt = {{(DATA_WIDTH-8){r_sign & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{(DATA_WIDTH-16){r_sign & w_half[15]}}, w_half};
      default: w_fmt = r_rdata;
    endcase
  end

  assign Dcache_Misalign = Mem_DcacheEN & w_bad;
  assign Dcache_StallReq = (w_accept & (r_state != DONE)) | (r_state == REQ) | (r_state == RESP);
  assign Dcache_DataRd   = (r_state == DONE && !r_we && !r_err) ? w_fmt : '0;
  assign Dcache_BusErr   = (r_state == DONE) & r_err;
  assign Bus_ReqValid    = (r_state == REQ);
  assign Bus_ReqWe       = r_we;
  assign Bus_ReqAddr     = r_addr;
  assign Bus_ReqWdata    = r_wdata;
  assign Bus_ReqStrb     = r_strb;

endmodule

// File: tb/tb_dcache_bus_bridge.sv
// Directed bench for dcache_bus_bridge: loads, stores, backpressure,
// misalignment, timeout, back-to-back and reset mid-transaction.
module tb_dcache_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Mem_DcacheEN;
  logic        Mem_DcacheRd;
  logic [1:0]  Mem_DcacheWidth;
  logic [31:0] Mem_DcacheAddr;
  logic        Mem_DcacheSign;
  logic [31:0] EXMem_Rs2Data;
  logic [31:0] Dcache_DataRd;
  logic        Dcache_StallReq;
  logic        Dcache_Misalign;
  logic        Dcache_BusErr;
  logic        Bus_ReqValid;
  logic        Bus_ReqReady;
  logic        Bus_ReqWe;
  logic [31:0] Bus_ReqAddr;
  logic [31:0] Bus_ReqWdata;
  logic [3:0]  Bus_ReqStrb;
  logic        Bus_RspValid;
  logic [31:0] Bus_RspData;
  logic        Bus_RspErr;

  int n_chk = 0;
  int n_err = 0;

  dcache_bus_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Mem_DcacheEN    (Mem_DcacheEN),
    .Mem_DcacheRd    (Mem_DcacheRd),
    .Mem_DcacheWidth (Mem_DcacheWidth),
    .Mem_DcacheAddr  (Mem_DcacheAddr),
    .Mem_DcacheSign  (Mem_DcacheSign),
    .EXMem_Rs2Data   (EXMem_Rs2Data),
    .Dcache_DataRd   (Dcache_DataRd),
    .Dcache_StallReq (Dcache_StallReq),
    .Dcache_Misalign (Dcache_Misalign),
    .Dcache_BusErr   (Dcache_BusErr),
    .Bus_ReqValid    (Bus_ReqValid),
    .Bus_ReqReady    (Bus_ReqReady),
    .Bus_ReqWe       (Bus_ReqWe),
    .Bus_ReqAddr     (Bus_ReqAddr),
    .Bus_ReqWdata    (Bus_ReqWdata),
    .Bus_ReqStrb     (Bus_ReqStrb),
    .Bus_RspValid    (Bus_RspValid),
    .Bus_RspData     (Bus_RspData),
    .Bus_RspErr      (Bus_RspErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic [1:0] w, input logic [31:0] a,
                     input logic s, input logic [31:0] d);
    Mem_DcacheEN    = 1'b1;
    Mem_DcacheRd    = rd;
    Mem_DcacheWidth = w;
    Mem_DcacheAddr  = a;
    Mem_DcacheSign  = s;
    EXMem_Rs2Data   = d;
  endtask

  initial begin
    rst_n = 1'b0;
    Mem_DcacheEN = 1'b0; Mem_DcacheRd = 1'b0; Mem_DcacheWidth = 2'b00;
    Mem_DcacheAddr = '0; Mem_DcacheSign = 1'b0; EXMem_Rs2Data = '0;
    Bus_ReqReady = 1'b0; Bus_RspValid = 1'b0; Bus_RspData = '0; Bus_RspErr = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(Bus_ReqValid), 32'd0);
    check("rst_we", 32'(Bus_ReqWe), 32'd0);
    check("rst_strb", 32'(Bus_ReqStrb), 32'd0);
    check("rst_data", Dcache_DataRd, 32'd0);
    check("rst_stall", 32'(Dcache_StallReq), 32'd0);
    check("rst_buserr", 32'(Dcache_BusErr), 32'd0);
    check("rst_misalign", 32'(Dcache_Misalign), 32'd0);
    rst_n = 1'b1;
    tick();

    // LB 0x103 signed, 1-cycle response
    req(1'b1, 2'b00, 32'h103, 1'b1, 32'h0);
    Bus_ReqReady = 1'b1;
    #1;
    check("lb_idle_stall", 32'(Dcache_StallReq), 32'd1);
    check("lb_idle_valid", 32'(Bus_ReqValid), 32'd0);
    tick();
    check("lb_req_valid", 32'(Bus_ReqValid), 32'd1);
    check("lb_req_addr", Bus_ReqAddr, 32'h100);
    check("lb_req_strb", 32'(Bus_ReqStrb), 32'h0);
    check("lb_req_we", 32'(Bus_ReqWe), 32'd0);
    check("lb_req_stall", 32'(Dcache_StallReq), 32'd1);
    tick();
    Bus_ReqReady = 1'b0;
    Bus_RspValid = 1'b1; Bus_RspData = 32'h80FF_0000;
    #1;
    check("lb_resp_stall", 32'(Dcache_StallReq), 32'd1);
    check("lb_resp_data", Dcache_DataRd, 32'd0);
    tick();
    Bus_RspValid = 1'b0;
    #1;
    check("lb_done_data", Dcache_DataRd, 32'hFFFF_FF80);
    check("lb_done_stall", 32'(Dcache_StallReq), 32'd0);
    check("lb_done_err", 32'(Dcache_BusErr), 32'd0);
    tick();
    Mem_DcacheEN = 1'b0;
    #1;
    check("lb_after_data", Dcache_DataRd, 32'd0);

    // SH 0x202 with Ready low for 4 REQ cycles
    req(1'b0, 2'b01, 32'h202, 1'b0, 32'h1234_ABCD);
    tick();
    for (int k = 0; k < 5; k++) begin
      Bus_ReqReady = (k == 4);
      #1;
      check("sh_valid", 32'(Bus_ReqValid), 32'd1);
      check("sh_addr", Bus_ReqAddr, 32'h200);
      check("sh_strb", 32'(Bus_ReqStrb), 32'hC);
      check("sh_wdata", Bus_ReqWdata, 32'hABCD_ABCD);
      check("sh_we", 32'(Bus_ReqWe), 32'd1);
      check("sh_stall", 32'(Dcache_StallReq), 32'd1);
      tick();
    end
    Bus_ReqReady = 1'b0;
    Bus_RspValid = 1'b1; Bus_RspData = 32'h5555_5555; Bus_RspErr = 1'b0;
    #1;
    check("sh_resp_valid", 32'(Bus_ReqValid), 32'd0);
    tick();
    Bus_RspValid = 1'b0;
    #1;
    check("sh_done_stall", 32'(Dcache_StallReq), 32'd0);
    check("sh_done_data", Dcache_DataRd, 32'd0);
    check("sh_done_err", 32'(Dcache_BusErr), 32'd0);
    tick();
    Mem_DcacheEN = 1'b0;

    // misaligned word and illegal width
    req(1'b1, 2'b10, 32'h101, 1'b0, 32'h0);
    #1;
    check("mis_w_flag", 32'(Dcache_Misalign), 32'd1);
    check("mis_w_stall", 32'(Dcache_StallReq), 32'd0);
    check("mis_w_data", Dcache_DataRd, 32'd0);
    tick();
    check("mis_w_valid", 32'(Bus_ReqValid), 32'd0);
    req(1'b1, 2'b11, 32'h100, 1'b0, 32'h0);
    #1;
    check("mis_11_flag", 32'(Dcache_Misalign), 32'd1);
    check("mis_11_stall", 32'(Dcache_StallReq), 32'd0);
    tick();
    check("mis_11_valid", 32'(Bus_ReqValid), 32'd0);
    check("mis_11_data", Dcache_DataRd, 32'd0);
    Mem_DcacheEN = 1'b0;
    tick();

    // LW 0x40 timeout: 8 RESP cycles, then DONE with error
    req(1'b1, 2'b10, 32'h40, 1'b0, 32'h0);
    Bus_ReqReady = 1'b1;
    tick();
    tick();
    Bus_ReqReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("to_resp_stall", 32'(Dcache_StallReq), 32'd1);
      check("to_resp_err", 32'(Dcache_BusErr), 32'd0);
      tick();
    end
    check("to_done_err", 32'(Dcache_BusErr), 32'd1);
    check("to_done_data", Dcache_DataRd, 32'd0);
    check("to_done_stall", 32'(Dcache_StallReq), 32'd0);
    tick();
    Mem_DcacheEN = 1'b0;
    #1;
    check("to_err_pulse", 32'(Dcache_BusErr), 32'd0);

    // LHU 0x12 then SW 0x20 right after, store gets an error response
    req(1'b1, 2'b01, 32'h12, 1'b0, 32'h0);
    Bus_ReqReady = 1'b1;
    tick();
    tick();
    Bus_ReqReady = 1'b0;
    Bus_RspValid = 1'b1; Bus_RspData = 32'hBEEF_0000;
    tick();
    Bus_RspValid = 1'b0;
    #1;
    check("b2b_lhu_data", Dcache_DataRd, 32'h0000_BEEF);
    tick();
    req(1'b0, 2'b10, 32'h20, 1'b0, 32'hCAFE_F00D);
    Bus_ReqReady = 1'b1;
    #1;
    check("b2b_idle_stall", 32'(Dcache_StallReq), 32'd1);
    check("b2b_idle_valid", 32'(Bus_ReqValid), 32'd0);
    tick();
    check("b2b_sw_valid", 32'(Bus_ReqValid), 32'd1);
    check("b2b_sw_addr", Bus_ReqAddr, 32'h20);
    check("b2b_sw_strb", 32'(Bus_ReqStrb), 32'hF);
    check("b2b_sw_wdata", Bus_ReqWdata, 32'hCAFE_F00D);
    tick();
    Bus_ReqReady = 1'b0;
    Bus_RspValid = 1'b1; Bus_RspErr = 1'b1; Bus_RspData = 32'h0;
    tick();
    Bus_RspValid = 1'b0; Bus_RspErr = 1'b0;
    #1;
    check("b2b_sw_err", 32'(Dcache_BusErr), 32'd1);
    check("b2b_sw_data", Dcache_DataRd, 32'd0);
    tick();
    Mem_DcacheEN = 1'b0;
    #1;
    check("b2b_err_pulse", 32'(Dcache_BusErr), 32'd0);

    // reset during RESP, then a late response
    req(1'b1, 2'b10, 32'h80, 1'b0, 32'h0);
    Bus_ReqReady = 1'b1;
    tick();
    tick();
    Bus_ReqReady = 1'b0;
    tick();
    check("rmid_resp_stall", 32'(Dcache_StallReq), 32'd1);
    rst_n = 1'b0;
    Mem_DcacheEN = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("rmid_valid", 32'(Bus_ReqValid), 32'd0);
    check("rmid_stall", 32'(Dcache_StallReq), 32'd0);
    Bus_RspValid = 1'b1; Bus_RspData = 32'h1234_5678; Bus_RspErr = 1'b1;
    tick();
    Bus_RspValid = 1'b0; Bus_RspErr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rmid_late_data", Dcache_DataRd, 32'd0);
      check("rmid_late_err", 32'(Dcache_BusErr), 32'd0);
      check("rmid_late_valid", 32'(Bus_ReqValid), 32'd0);
      check("rmid_late_stall", 32'(Dcache_StallReq), 32'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
